// File: rtl/mpmc10_strip_seq.sv
// mpmc10_strip_seq: read-burst sequencer for the mpmc10 memory controller.
// Issues num_strips+1 strip read commands to the MIG application interface,
// stepping the address by one strip per accepted command, counts returning
// read-data beats, and pulses done once the last strip has arrived.
// Optional no-progress watchdog: define MPMC10_STRIP_TIMEOUT_EN.
module mpmc10_strip_seq #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned STRIP_BYTES = 16,
  parameter int unsigned TIMEOUT     = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [5:0]        num_strips,
  output logic              busy,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  input  logic              app_rdy,
  input  logic              app_rd_data_valid,
  output logic [5:0]        req_cnt,
  output logic [5:0]        resp_cnt,
  output logic              done,
  output logic              timeout
);

  localparam int unsigned Shift = $clog2(STRIP_BYTES);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [5:0]        nstr_q, nstr_d;
  logic [5:0]        req_q, req_d;
  logic [5:0]        resp_q, resp_d;
  logic              timeout_q, timeout_d;
  logic              wd_fire;
  logic              active;

  // Sub-strip address bits are discarded when the base is captured.
  logic [Shift-1:0]  unused_addr_lo;
  assign unused_addr_lo = addr[Shift-1:0];

  assign active = (state_q == StIssue) || (state_q == StWait);

`ifdef MPMC10_STRIP_TIMEOUT_EN
  localparam int unsigned WdW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;

  logic [WdW-1:0] wd_q, wd_d;
  logic           progress;

  // No-progress counter: cleared by start, an accepted command or a data beat.
  always_comb begin
    wd_d     = wd_q;
    progress = ((state_q == StIssue) && app_rdy) || app_rd_data_valid;
    if ((state_q == StIdle) && start) begin
      wd_d = '0;
    end else if (active) begin
      wd_d = progress ? '0 : wd_q + 1'b1;
    end
  end

  assign wd_fire = active && (wd_q == WdW'(TIMEOUT));

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  logic unused_timeout_param;
  assign unused_timeout_param = ^TIMEOUT;
  assign wd_fire = 1'b0;
`endif

  // Next-state, capture and strip counting.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    nstr_d    = nstr_q;
    req_d     = req_q;
    resp_d    = resp_q;
    timeout_d = timeout_q;

    // Beats only count while a burst is in flight; saturate at nstr.
    if (active && app_rd_data_valid && (resp_q != nstr_q)) begin
      resp_d = resp_q + 6'd1;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          base_d    = {addr[ADDR_W-1:Shift], {Shift{1'b0}}};
          nstr_d    = num_strips;
          req_d     = '0;
          resp_d    = '0;
          timeout_d = 1'b0;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        if (app_rdy) begin
          if (req_q == nstr_q) begin
            state_d = StWait;
          end else begin
            req_d = req_q + 6'd1;
          end
        end
      end
      StWait: begin
        // The final-strip beat is only honoured here; in ISSUE it is ignored.
        if (app_rd_data_valid && (resp_q == nstr_q)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (wd_fire) begin
      state_d   = StDone;
      timeout_d = 1'b1;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      base_q    <= '0;
      nstr_q    <= '0;
      req_q     <= '0;
      resp_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      nstr_q    <= nstr_d;
      req_q     <= req_d;
      resp_q    <= resp_d;
      timeout_q <= timeout_d;
    end
  end

  // Outputs decode registers only; nothing from app_rdy/app_rd_data_valid.
  assign busy     = (state_q != StIdle);
  assign app_en   = (state_q == StIssue);
  assign done     = (state_q == StDone);
  assign app_cmd  = 3'b001;
  assign app_addr = base_q + (ADDR_W'(req_q) << Shift);
  assign req_cnt  = req_q;
  assign resp_cnt = resp_q;
  assign timeout  = timeout_q;

endmodule
